multicycle_control_v2: RTL and testbench

//  Parametrised multicycle RV control FSM; drives `processing` datapath flags from IR opcode/funct3.

---
 rtl/multicycle_control_v2.sv | 208 ++++++++++++++++++++
 tb/tb_multicycle_control_v2.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_v2.sv
// Multicycle RV control FSM: decodes IR opcode/funct3 into datapath strobes,
// with ready-handshaked memories, wait timeouts, a sticky trap and a retire counter.
module multicycle_control_v2 #(
   parameter int MEM_TIMEOUT = 15,
   parameter int TO_W        = $clog2(MEM_TIMEOUT + 1),
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [31:0]      instruction,
   input  logic             imem_ready,
   input  logic             dmem_ready,
   input  logic             alu_zero,
   input  logic             alu_lt,
   output logic             PCWriteEn,
   output logic [1:0]       PCSource,
   output logic [1:0]       ALUSrcA,
   output logic [1:0]       ALUSrcB,
   output logic [1:0]       ALUOp,
   output logic             LoadAOut,
   output logic             LoadRegA,
   output logic             LoadRegB,
   output logic             RegWrite,
   output logic [1:0]       MemToReg,
   output logic             IMemRead,
   output logic             IRWrite,
   output logic             DMemRead,
   output logic             DMemWrite,
   output logic             LoadMDR,
   output logic             Trap,
   output logic [1:0]       TrapCause,
   output logic [CNT_W-1:0] InstrRetired
);

   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_LD  = 7'b0000011;
   localparam logic [6:0] OP_SD  = 7'b0100011;
   localparam logic [6:0] OP_BR  = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;

   typedef enum logic [3:0] {
      FETCH, DECODE, MEM_ADDR, MEM_LD, MEM_SD, WB_LD,
      EXEC_R, EXEC_I, WB_ALU, BRANCH, JAL, TRAP
   } state_t;

   state_t          state, nextState;
   logic [TO_W-1:0] waitCnt;
   logic [1:0]      causeNext;
   logic            pcWrite, pcWriteCond, taken, timeoutHit;
   logic [6:0]      opcode;
   logic [2:0]      funct3;

   assign opcode     = instruction[6:0];
   assign funct3     = instruction[14:12];
   assign timeoutHit = (waitCnt == TO_W'(MEM_TIMEOUT - 1));

   // Strobes are Mealy on state plus ready/flag inputs so a memory handshake
   // completes in the cycle ready is seen; reset masks every strobe at once.
   always_comb begin
      // NOTE: every output gets a default before the case so no path can infer a latch.
      nextState   = state;
      causeNext   = 2'b00;
      pcWrite     = 1'b0;
      pcWriteCond = 1'b0;
      taken       = 1'b0;
      PCSource    = 2'b00;
      ALUSrcA     = 2'b00;
      ALUSrcB     = 2'b00;
      ALUOp       = 2'b00;
      LoadAOut    = 1'b0;
      LoadRegA    = 1'b0;
      LoadRegB    = 1'b0;
      RegWrite    = 1'b0;
      MemToReg    = 2'b00;
      IMemRead    = 1'b0;
      IRWrite     = 1'b0;
      DMemRead    = 1'b0;
      DMemWrite   = 1'b0;
      LoadMDR     = 1'b0;
      if (reset) begin
         case (state)
            FETCH: begin
               IMemRead = 1'b1;
               if (imem_ready) begin
                  IRWrite   = 1'b1;
                  pcWrite   = 1'b1;
                  ALUSrcB   = 2'b01;
                  nextState = DECODE;
               end else if (timeoutHit) begin
                  nextState = TRAP;
                  causeNext = 2'b10;
               end
            end
            DECODE: begin
               LoadRegA = 1'b1;
               LoadRegB = 1'b1;
               LoadAOut = 1'b1;
               ALUSrcA  = 2'b10;
               ALUSrcB  = 2'b11;
               case (opcode)
                  OP_LD, OP_SD: nextState = MEM_ADDR;
                  OP_R:         nextState = EXEC_R;
                  OP_I:         nextState = EXEC_I;
                  OP_BR:        nextState = BRANCH;
                  OP_JAL:       nextState = JAL;
                  default: begin
                     nextState = TRAP;
                     causeNext = 2'b01;
                  end
               endcase
            end
            MEM_ADDR: begin
               LoadAOut  = 1'b1;
               ALUSrcA   = 2'b01;
               ALUSrcB   = 2'b10;
               nextState = (opcode == OP_SD) ? MEM_SD : MEM_LD;
            end
            MEM_LD: begin
               DMemRead = 1'b1;
               if (dmem_ready) begin
                  LoadMDR   = 1'b1;
                  nextState = WB_LD;
               end else if (timeoutHit) begin
                  nextState = TRAP;
                  causeNext = 2'b11;
               end
            end
            MEM_SD: begin
               DMemWrite = 1'b1;
               if (dmem_ready) begin
                  nextState = FETCH;
               end else if (timeoutHit) begin
                  nextState = TRAP;
                  causeNext = 2'b11;
               end
            end
            WB_LD: begin
               RegWrite  = 1'b1;
               MemToReg  = 2'b01;
               nextState = FETCH;
            end
            EXEC_R, EXEC_I: begin
               LoadAOut  = 1'b1;
               ALUSrcA   = 2'b01;
               ALUSrcB   = (state == EXEC_I) ? 2'b10 : 2'b00;
               ALUOp     = 2'b10;
               nextState = WB_ALU;
            end
            WB_ALU: begin
               RegWrite  = 1'b1;
               nextState = FETCH;
            end
            BRANCH: begin
               ALUSrcA     = 2'b01;
               ALUOp       = 2'b01;
               PCSource    = 2'b01;
               pcWriteCond = 1'b1;
               nextState   = FETCH;
               case (funct3)
                  3'b000:  taken = alu_zero;
                  3'b001:  taken = !alu_zero;
                  3'b100:  taken = alu_lt;
                  3'b101:  taken = !alu_lt;
                  default: begin
                     pcWriteCond = 1'b0;
                     nextState   = TRAP;
                     causeNext   = 2'b01;
                  end
               endcase
            end
            JAL: begin
               RegWrite  = 1'b1;
               MemToReg  = 2'b10;
               pcWrite   = 1'b1;
               PCSource  = 2'b01;
               nextState = FETCH;
            end
            TRAP:    nextState = TRAP;
            default: nextState = FETCH;
         endcase
      end
   end

   assign PCWriteEn = pcWrite | (pcWriteCond & taken);
   assign Trap      = reset & (state == TRAP);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= FETCH;
         waitCnt      <= '0;
         InstrRetired <= '0;
         TrapCause    <= 2'b00;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state <= nextState;
         if (nextState != state)
            waitCnt <= '0;
         else if (state == FETCH || state == MEM_LD || state == MEM_SD)
            waitCnt <= waitCnt + TO_W'(1);
         if (nextState == FETCH && state != FETCH)
            InstrRetired <= InstrRetired + CNT_W'(1);
         if (nextState == TRAP && state != TRAP)
            TrapCause <= causeNext;
      end
   end

endmodule

// File: tb/tb_multicycle_control_v2.sv
// Scoreboarded directed test of multicycle_control_v2: stimulus pushes the
// expected per-cycle control word, a negedge monitor pops and compares.
module tb_multicycle_control_v2;

   typedef struct packed {
      logic       pcWriteEn;
      logic [1:0] pcSource;
      logic [1:0] aluSrcA;
      logic [1:0] aluSrcB;
      logic [1:0] aluOp;
      logic       loadAOut;
      logic       loadRegA;
      logic       loadRegB;
      logic       regWrite;
      logic [1:0] memToReg;
      logic       iMemRead;
      logic       irWrite;
      logic       dMemRead;
      logic       dMemWrite;
      logic       loadMdr;
      logic       trap;
      logic [1:0] trapCause;
   } ctrl_t;

   typedef struct packed {
      logic [63:0] tag;
      ctrl_t       c;
      logic [31:0] ret;
   } exp_t;

   localparam ctrl_t C_ZERO      = '{default: 0};
   localparam ctrl_t C_FETCH_W   = '{iMemRead: 1, default: 0};
   localparam ctrl_t C_FETCH_GO  = '{iMemRead: 1, irWrite: 1, pcWriteEn: 1, aluSrcB: 2'b01, default: 0};
   localparam ctrl_t C_DECODE    = '{loadRegA: 1, loadRegB: 1, loadAOut: 1, aluSrcA: 2'b10, aluSrcB: 2'b11, default: 0};
   localparam ctrl_t C_EXEC_R    = '{loadAOut: 1, aluSrcA: 2'b01, aluOp: 2'b10, default: 0};
   localparam ctrl_t C_EXEC_I    = '{loadAOut: 1, aluSrcA: 2'b01, aluSrcB: 2'b10, aluOp: 2'b10, default: 0};
   localparam ctrl_t C_WB_ALU    = '{regWrite: 1, default: 0};
   localparam ctrl_t C_MEM_ADDR  = '{loadAOut: 1, aluSrcA: 2'b01, aluSrcB: 2'b10, default: 0};
   localparam ctrl_t C_LD_WAIT   = '{dMemRead: 1, default: 0};
   localparam ctrl_t C_LD_GO     = '{dMemRead: 1, loadMdr: 1, default: 0};
   localparam ctrl_t C_WB_LD     = '{regWrite: 1, memToReg: 2'b01, default: 0};
   localparam ctrl_t C_SD        = '{dMemWrite: 1, default: 0};
   localparam ctrl_t C_BR_TAKEN  = '{aluSrcA: 2'b01, aluOp: 2'b01, pcSource: 2'b01, pcWriteEn: 1, default: 0};
   localparam ctrl_t C_BR_NOT    = '{aluSrcA: 2'b01, aluOp: 2'b01, pcSource: 2'b01, default: 0};
   localparam ctrl_t C_JAL       = '{regWrite: 1, memToReg: 2'b10, pcWriteEn: 1, pcSource: 2'b01, default: 0};
   localparam ctrl_t C_TRAP_ILL  = '{trap: 1, trapCause: 2'b01, default: 0};
   localparam ctrl_t C_TRAP_IMEM = '{trap: 1, trapCause: 2'b10, default: 0};
   localparam ctrl_t C_TRAP_DMEM = '{trap: 1, trapCause: 2'b11, default: 0};

   localparam logic [31:0] I_ADD  = 32'h003100B3;
   localparam logic [31:0] I_ADDI = 32'h00500093;
   localparam logic [31:0] I_LD   = 32'h00013083;
   localparam logic [31:0] I_SD   = 32'h00113023;
   localparam logic [31:0] I_BEQ  = 32'h00208463;
   localparam logic [31:0] I_BNE  = 32'h00209463;
   localparam logic [31:0] I_BLT  = 32'h0020C463;
   localparam logic [31:0] I_BGE  = 32'h0020D463;
   localparam logic [31:0] I_B010 = 32'h0020A463;
   localparam logic [31:0] I_JAL  = 32'h008000EF;
   localparam logic [31:0] I_ILL  = 32'h0000007F;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] instruction = 32'h0;
   logic        imem_ready = 1'b1;
   logic        dmem_ready = 1'b1;
   logic        alu_zero = 1'b0;
   logic        alu_lt = 1'b0;
   logic        PCWriteEn, LoadAOut, LoadRegA, LoadRegB, RegWrite;
   logic        IMemRead, IRWrite, DMemRead, DMemWrite, LoadMDR, Trap;
   logic [1:0]  PCSource, ALUSrcA, ALUSrcB, ALUOp, MemToReg, TrapCause;
   logic [31:0] InstrRetired;

   exp_t expQ[$];
   int   checks = 0;
   int   errors = 0;

   multicycle_control_v2 #(.MEM_TIMEOUT(15), .CNT_W(32)) dut (
      .clk(clk), .reset(reset), .instruction(instruction),
      .imem_ready(imem_ready), .dmem_ready(dmem_ready),
      .alu_zero(alu_zero), .alu_lt(alu_lt),
      .PCWriteEn(PCWriteEn), .PCSource(PCSource), .ALUSrcA(ALUSrcA),
      .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .LoadAOut(LoadAOut),
      .LoadRegA(LoadRegA), .LoadRegB(LoadRegB), .RegWrite(RegWrite),
      .MemToReg(MemToReg), .IMemRead(IMemRead), .IRWrite(IRWrite),
      .DMemRead(DMemRead), .DMemWrite(DMemWrite), .LoadMDR(LoadMDR),
      .Trap(Trap), .TrapCause(TrapCause), .InstrRetired(InstrRetired)
   );

   always #5 clk = ~clk;

   task automatic check(input exp_t e, input ctrl_t act, input logic [31:0] actRet);
      checks++;
      if (act !== e.c || actRet !== e.ret) begin
         errors++;
         $display("FAIL %0s: ctrl=%h retired=%0d, required ctrl=%h retired=%0d",
                  e.tag, act, actRet, e.c, e.ret);
      end
   endtask

   // Monitor: one expected control word per cycle, sampled mid-cycle.
   always @(negedge clk) begin
      if (expQ.size() > 0) begin
         exp_t e;
         ctrl_t act;
         e = expQ.pop_front();
         act = {PCWriteEn, PCSource, ALUSrcA, ALUSrcB, ALUOp, LoadAOut, LoadRegA,
                LoadRegB, RegWrite, MemToReg, IMemRead, IRWrite, DMemRead,
                DMemWrite, LoadMDR, Trap, TrapCause};
         check(e, act, InstrRetired);
      end
   end

   task automatic step(input ctrl_t c, input logic [31:0] ret, input logic [63:0] tag);
      expQ.push_back('{tag: tag, c: c, ret: ret});
      @(posedge clk);
      #1;
   endtask

   task automatic resetPulse();
      reset = 1'b0;
      step(C_ZERO, 0, "RESET");
      reset = 1'b1;
      imem_ready = 1'b1;
      dmem_ready = 1'b1;
   endtask

   task automatic fetchDecode(input logic [31:0] instr, input logic [31:0] ret);
      instruction = instr;
      imem_ready = 1'b1;
      step(C_FETCH_GO, ret, "FETCH");
      step(C_DECODE, ret, "DECODE");
   endtask

   initial begin
      #1 reset = 1'b0;
      @(posedge clk);
      #1;
      step(C_ZERO, 0, "RESET0");
      step(C_ZERO, 0, "RESET1");
      reset = 1'b1;

      // ADD then ADDI
      fetchDecode(I_ADD, 0);
      step(C_EXEC_R, 0, "EXEC_R");
      step(C_WB_ALU, 0, "WB_ALU");
      fetchDecode(I_ADDI, 1);
      step(C_EXEC_I, 1, "EXEC_I");
      step(C_WB_ALU, 1, "WB_ALU");

      // LD with three wait cycles, then zero-wait SD
      fetchDecode(I_LD, 2);
      step(C_MEM_ADDR, 2, "LD_ADDR");
      dmem_ready = 1'b0;
      for (int i = 0; i < 3; i++) step(C_LD_WAIT, 2, "LD_WAIT");
      dmem_ready = 1'b1;
      step(C_LD_GO, 2, "LD_GO");
      step(C_WB_LD, 2, "WB_LD");
      fetchDecode(I_SD, 3);
      step(C_MEM_ADDR, 3, "SD_ADDR");
      step(C_SD, 3, "SD_GO");

      // Branches: BNE taken/not, BLT taken, BGE not, BEQ taken
      alu_zero = 1'b0;
      fetchDecode(I_BNE, 4);
      step(C_BR_TAKEN, 4, "BNE_T");
      alu_zero = 1'b1;
      fetchDecode(I_BNE, 5);
      step(C_BR_NOT, 5, "BNE_N");
      alu_lt = 1'b1;
      fetchDecode(I_BLT, 6);
      step(C_BR_TAKEN, 6, "BLT_T");
      fetchDecode(I_BGE, 7);
      step(C_BR_NOT, 7, "BGE_N");
      fetchDecode(I_BEQ, 8);
      step(C_BR_TAKEN, 8, "BEQ_T");
      fetchDecode(I_JAL, 9);
      step(C_JAL, 9, "JAL");

      // One imem wait, then illegal branch funct3 traps without retiring
      instruction = I_B010;
      imem_ready = 1'b0;
      step(C_FETCH_W, 10, "F_WAIT");
      fetchDecode(I_B010, 10);
      step(C_BR_NOT, 10, "BR_ILL");
      step(C_TRAP_ILL, 10, "TRAP01");
      step(C_TRAP_ILL, 10, "TRAP01H");

      // Illegal opcode
      resetPulse();
      fetchDecode(I_ILL, 0);
      step(C_TRAP_ILL, 0, "TRAP7F");
      step(C_TRAP_ILL, 0, "TRAP7FH");

      // imem stuck low: exactly 15 FETCH cycles, then sticky trap
      resetPulse();
      instruction = I_ADD;
      imem_ready = 1'b0;
      for (int i = 0; i < 15; i++) step(C_FETCH_W, 0, "IM_WAIT");
      imem_ready = 1'b1;
      for (int i = 0; i < 3; i++) step(C_TRAP_IMEM, 0, "TRAP10");

      // dmem stuck low during LD: 15 waits, then trap cause 11
      resetPulse();
      fetchDecode(I_LD, 0);
      step(C_MEM_ADDR, 0, "LD_ADDR");
      dmem_ready = 1'b0;
      for (int i = 0; i < 15; i++) step(C_LD_WAIT, 0, "DM_WAIT");
      step(C_TRAP_DMEM, 0, "TRAP11");

      // Reset mid SD wait, then JAL links with MemToReg=10
      resetPulse();
      fetchDecode(I_ADD, 0);
      step(C_EXEC_R, 0, "EXEC_R");
      step(C_WB_ALU, 0, "WB_ALU");
      fetchDecode(I_SD, 1);
      step(C_MEM_ADDR, 1, "SD_ADDR");
      dmem_ready = 1'b0;
      step(C_SD, 1, "SD_WAIT");
      step(C_SD, 1, "SD_WAIT");
      resetPulse();
      fetchDecode(I_JAL, 0);
      step(C_JAL, 0, "JAL_RST");
      step(C_FETCH_GO, 1, "FETCH");

      repeat (2) @(negedge clk);
      checks++;
      if (expQ.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d entries left, required 0", expQ.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
